button_conditioner: RTL

//  Conditions the four raw Basys 3 push-buttons (BtnU/L/D/R) ahead of square_controller.

---
 rtl/button_conditioner_pkg.sv | 22 ++
 rtl/button_conditioner_debounce.sv | 73 +++++++
 rtl/button_conditioner.sv | 78 +++++++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared button definitions for the input-conditioning path and square_controller:
// bit positions of the four Basys 3 buttons and the opposing-pair request mask.
package button_conditioner_pkg;

    localparam int N_BTN = 4;
    localparam int BTN_U = 3;
    localparam int BTN_L = 2;
    localparam int BTN_D = 1;
    localparam int BTN_R = 0;

    // Opposing requests (U/D, L/R) cancel each other; diagonals pass through.
    function automatic logic [N_BTN-1:0] mask_opposing(input logic [N_BTN-1:0] req);
        logic [N_BTN-1:0] m;
        m        = req;
        m[BTN_U] = req[BTN_U] & ~req[BTN_D];
        m[BTN_D] = req[BTN_D] & ~req[BTN_U];
        m[BTN_L] = req[BTN_L] & ~req[BTN_R];
        m[BTN_R] = req[BTN_R] & ~req[BTN_L];
        return m;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce.sv
// One button lane: 2-FF synchroniser, debounce counter and registered
// press-edge detector. The debounced level only moves once the synchronised
// input has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync0_q;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync0_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync0_q <= sync1_q;
        end
    end

    // Any agreement with the current level restarts the count, so bounces never accumulate.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync0_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync0_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    // Rising-edge detect on the debounced level; the pulse lands the cycle after the rise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            stable_dly_q <= stable_q;
            press_q      <= stable_q & ~stable_dly_q;
        end
    end

    assign level_o = stable_q;
    assign press_o = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four raw push-buttons for square_controller: per-lane debounce
// and press detection, frame-aligned request latches consumed by refresh_tick,
// auto-repeat while a button is held, and opposing-pair cancellation.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_FRAMES   = 8
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             refresh_tick,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] move_req
);

    logic [N_BTN-1:0] rpt_fire;
    logic [N_BTN-1:0] req_q, req_d;

    for (genvar g = 0; g < N_BTN; g++) begin : g_lane
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk_i  (clk_100MHz),
            .rst_i  (reset),
            .raw_i  (btn_raw[g]),
            .level_o(btn_level[g]),
            .press_o(btn_press[g])
        );
    end

    if (REPEAT_FRAMES > 0) begin : g_rpt
        localparam int               RCNT_W    = $clog2(REPEAT_FRAMES + 1);
        localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_FRAMES - 1);

        logic [N_BTN-1:0][RCNT_W-1:0] rcnt_q, rcnt_d;

        // Count frames while held; fire on the frame that completes a repeat period.
        always_comb begin
            rpt_fire = '0;
            rcnt_d   = rcnt_q;
            for (int i = 0; i < N_BTN; i++) begin
                rpt_fire[i] = refresh_tick & btn_level[i] & (rcnt_q[i] == RCNT_LAST);
                if (btn_press[i] | ~btn_level[i]) begin
                    rcnt_d[i] = '0;
                end else if (refresh_tick) begin
                    rcnt_d[i] = rpt_fire[i] ? '0 : rcnt_q[i] + RCNT_W'(1);
                end
            end
        end

        // Repeat counters.
        always_ff @(posedge clk_100MHz or posedge reset) begin
            if (reset) rcnt_q <= '0;
            else       rcnt_q <= rcnt_d;
        end
    end else begin : g_norpt
        assign rpt_fire = '0;
    end

    // Set beats clear, so a press landing on refresh_tick survives into the next frame.
    always_comb begin
        req_d = (btn_press | rpt_fire) | (req_q & ~{N_BTN{refresh_tick}});
    end

    // Request latches.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) req_q <= '0;
        else       req_q <= req_d;
    end

    assign move_req = mask_opposing(req_q);

endmodule
